// File: rtl/pic_boot_sequencer.sv
// pic_boot_sequencer
//   Boot controller for the risc16f84 core. Holds the core in reset, streams
//   {lo, hi} byte pairs from a byte-wide source into 14-bit program RAM,
//   checks an 8-bit additive checksum, then releases the core.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       single-cycle pulse; starts/restarts a load (IDLE, RUN, ERROR only)
//   src_data    source byte
//   src_valid   source byte valid
//   src_ready   sequencer accepts a byte this cycle
//   pram_we     program RAM write enable
//   pram_addr   program RAM write address
//   pram_wdata  program RAM write data
//   core_reset  active-high reset to the core
//   busy        load in progress (LOAD_LO..RELEASE)
//   done        load succeeded, core running
//   err         checksum failed, core held in reset
module pic_boot_sequencer #(
   parameter int ADDR_W        = 10,
   parameter int NUM_WORDS     = 1024,
   parameter int AUTO_BOOT     = 1,
   parameter int RELEASE_DELAY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              pram_we,
   output logic [ADDR_W-1:0] pram_addr,
   output logic [13:0]       pram_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_WORDS - 1);
   localparam logic [7:0]        DELAY_INIT = 8'(RELEASE_DELAY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_LO,
      S_LOAD_HI,
      S_WRITE,
      S_CHECK,
      S_RELEASE,
      S_RUN,
      S_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   count_q, count_d;
   logic [7:0]          sum_q, sum_d;
   logic [7:0]          lo_q, lo_d;
   logic [7:0]          delay_q, delay_d;
   logic                src_ready_q, src_ready_d;
   logic                pram_we_q, pram_we_d;
   logic [ADDR_W-1:0]   pram_addr_q, pram_addr_d;
   logic [13:0]         pram_wdata_q, pram_wdata_d;
   logic                core_reset_q, core_reset_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                accept;

   // src_ready_q always reflects the current state, so it is the handshake term.
   assign accept = src_valid && src_ready_q;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      sum_d        = sum_q;
      lo_d         = lo_q;
      delay_d      = delay_q;
      pram_addr_d  = pram_addr_q;
      pram_wdata_d = pram_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (start || (AUTO_BOOT != 0)) begin
               state_d = S_LOAD_LO;
               count_d = '0;
               sum_d   = '0;
            end
         end
         S_LOAD_LO: begin
            if (accept) begin
               lo_d    = src_data;
               sum_d   = sum_q + src_data;
               state_d = S_LOAD_HI;
            end
         end
         S_LOAD_HI: begin
            if (accept) begin
               sum_d        = sum_q + src_data;
               pram_addr_d  = count_q;
               pram_wdata_d = {src_data[5:0], lo_q};
               state_d      = S_WRITE;
            end
         end
         S_WRITE: begin
            if (count_q == LAST_ADDR) begin
               state_d = S_CHECK;
            end else begin
               count_d = count_q + ADDR_W'(1);
               state_d = S_LOAD_LO;
            end
         end
         S_CHECK: begin
            if (accept) begin
               sum_d = sum_q + src_data;
               if (sum_d == 8'h00) begin
                  state_d = S_RELEASE;
                  delay_d = DELAY_INIT;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         S_RELEASE: begin
            // Loaded with DELAY-1 on entry so RUN is entered DELAY edges after the checksum.
            if (delay_q == 8'h00) state_d = S_RUN;
            else                  delay_d = delay_q - 8'h01;
         end
         S_RUN, S_ERROR: begin
            if (start) begin
               state_d = S_LOAD_LO;
               count_d = '0;
               sum_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      src_ready_d  = (state_d == S_LOAD_LO) || (state_d == S_LOAD_HI) || (state_d == S_CHECK);
      pram_we_d    = (state_d == S_WRITE);
      busy_d       = (state_d == S_LOAD_LO) || (state_d == S_LOAD_HI) || (state_d == S_WRITE) ||
                     (state_d == S_CHECK)   || (state_d == S_RELEASE);
      core_reset_d = (state_d != S_RUN);
      done_d       = (state_d == S_RUN);
      err_d        = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         sum_q        <= '0;
         lo_q         <= '0;
         delay_q      <= '0;
         src_ready_q  <= 1'b0;
         pram_we_q    <= 1'b0;
         pram_addr_q  <= '0;
         pram_wdata_q <= '0;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         sum_q        <= sum_d;
         lo_q         <= lo_d;
         delay_q      <= delay_d;
         src_ready_q  <= src_ready_d;
         pram_we_q    <= pram_we_d;
         pram_addr_q  <= pram_addr_d;
         pram_wdata_q <= pram_wdata_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign src_ready  = src_ready_q;
   assign pram_we    = pram_we_q;
   assign pram_addr  = pram_addr_q;
   assign pram_wdata = pram_wdata_q;
   assign core_reset = core_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_pic_boot_sequencer.sv
// Directed bench for pic_boot_sequencer: instance A auto-boots, instance B waits for start.
module tb_pic_boot_sequencer;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    src_data = '0;
   logic          a_start = 1'b0, a_valid = 1'b0;
   logic          b_start = 1'b0, b_valid = 1'b0;

   logic          a_ready, a_we, a_core_reset, a_busy, a_done, a_err;
   logic [AW-1:0] a_addr;
   logic [13:0]   a_wdata;
   logic          b_ready, b_we, b_core_reset, b_busy, b_done, b_err;
   logic [AW-1:0] b_addr;
   logic [13:0]   b_wdata;

   int tests = 0;
   int fails = 0;
   int sel   = 0;

   logic [AW-1:0] wq_addr[$];
   logic [13:0]   wq_data[$];

   logic [7:0]  stream [8] = '{8'h34, 8'h12, 8'hFF, 8'h3F, 8'h00, 8'h00, 8'h01, 8'h00};
   logic [13:0] exp_w  [4] = '{14'h1234, 14'h3FFF, 14'h0000, 14'h0001};

   always #5 clk = ~clk;

   pic_boot_sequencer #(.ADDR_W(AW), .NUM_WORDS(4), .AUTO_BOOT(1), .RELEASE_DELAY(4)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .src_data(src_data), .src_valid(a_valid),
      .src_ready(a_ready), .pram_we(a_we), .pram_addr(a_addr), .pram_wdata(a_wdata),
      .core_reset(a_core_reset), .busy(a_busy), .done(a_done), .err(a_err));

   pic_boot_sequencer #(.ADDR_W(AW), .NUM_WORDS(4), .AUTO_BOOT(0), .RELEASE_DELAY(4)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .src_data(src_data), .src_valid(b_valid),
      .src_ready(b_ready), .pram_we(b_we), .pram_addr(b_addr), .pram_wdata(b_wdata),
      .core_reset(b_core_reset), .busy(b_busy), .done(b_done), .err(b_err));

   // Log every RAM write from either instance (sampled mid-cycle).
   always @(negedge clk) begin
      if (a_we) begin
         wq_addr.push_back(a_addr);
         wq_data.push_back(a_wdata);
      end
      if (b_we) begin
         wq_addr.push_back(b_addr);
         wq_data.push_back(b_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic cur_ready();
      return (sel == 0) ? a_ready : b_ready;
   endfunction

   task automatic set_valid(input logic v);
      if (sel == 0) a_valid = v;
      else          b_valid = v;
   endtask

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      set_valid(1'b0);
      repeat (gap) @(negedge clk);
      src_data = b;
      set_valid(1'b1);
      n = 0;
      while (!cur_ready() && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("ready_timeout", 32'(cur_ready()), 32'd1);
      @(negedge clk);
   endtask

   task automatic send_stream(input logic [7:0] ck, input int maxgap);
      for (int i = 0; i < 8; i++)
         send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      send_byte(ck, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      set_valid(1'b0);
   endtask

   task automatic check_writes(input string tag);
      int n;
      n = wq_addr.size();
      check({tag, "_wcount"}, 32'(n), 32'd4);
      for (int i = 0; i < 4 && i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), 32'(wq_data[i]), 32'(exp_w[i]));
      end
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic check_a_reset_values(input string tag);
      check({tag, "_ready"},  32'(a_ready),      32'd0);
      check({tag, "_we"},     32'(a_we),         32'd0);
      check({tag, "_addr"},   32'(a_addr),       32'd0);
      check({tag, "_wdata"},  32'(a_wdata),      32'd0);
      check({tag, "_corerst"},32'(a_core_reset), 32'd1);
      check({tag, "_busy"},   32'(a_busy),       32'd0);
      check({tag, "_done"},   32'(a_done),       32'd0);
      check({tag, "_err"},    32'(a_err),        32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_a_reset_values("rst0");
      reset = 1'b0;
      @(negedge clk);
      check("auto_ready", 32'(a_ready), 32'd1);
      check("auto_busy",  32'(a_busy),  32'd1);
      check("auto_crst",  32'(a_core_reset), 32'd1);
      check("b_idle_ready", 32'(b_ready), 32'd0);
      check("b_idle_crst",  32'(b_core_reset), 32'd1);

      // Good load, no gaps; release timing
      sel = 0;
      send_stream(8'h7B, 0);
      check_writes("good");
      check("rel_busy", 32'(a_busy), 32'd1);
      repeat (3) @(negedge clk);
      check("rel_crst_hold", 32'(a_core_reset), 32'd1);
      check("rel_done_low",  32'(a_done), 32'd0);
      @(negedge clk);
      check("run_crst",  32'(a_core_reset), 32'd0);
      check("run_done",  32'(a_done), 32'd1);
      check("run_busy",  32'(a_busy), 32'd0);
      check("run_err",   32'(a_err), 32'd0);
      check("run_ready", 32'(a_ready), 32'd0);

      // start in RUN, then bad checksum
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      check("restart_crst",  32'(a_core_reset), 32'd1);
      check("restart_busy",  32'(a_busy), 32'd1);
      check("restart_done",  32'(a_done), 32'd0);
      check("restart_ready", 32'(a_ready), 32'd1);
      send_stream(8'h7C, 0);
      check_writes("bad");
      check("bad_err",  32'(a_err), 32'd1);
      check("bad_done", 32'(a_done), 32'd0);
      check("bad_busy", 32'(a_busy), 32'd0);
      repeat (6) @(negedge clk);
      check("bad_crst_held", 32'(a_core_reset), 32'd1);
      check("bad_err_held",  32'(a_err), 32'd1);

      // start in ERROR, correct stream with random gaps
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      check("retry_err_clr", 32'(a_err), 32'd0);
      check("retry_busy",    32'(a_busy), 32'd1);
      send_stream(8'h7B, 5);
      repeat (4) @(negedge clk);
      check_writes("gaps");
      check("gaps_done", 32'(a_done), 32'd1);
      check("gaps_err",  32'(a_err), 32'd0);
      check("gaps_crst", 32'(a_core_reset), 32'd0);

      // Reset during word-2 hi byte
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
      a_valid = 1'b0;
      check("mid_ready_hi", 32'(a_ready), 32'd1);
      check("mid_wcount",   32'(wq_addr.size()), 32'd2);
      #2 reset = 1'b1;
      #1 check_a_reset_values("rst_async");
      wq_addr.delete();
      wq_data.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_reload_ready", 32'(a_ready), 32'd1);
      send_stream(8'h7B, 0);
      repeat (4) @(negedge clk);
      check_writes("reload");
      check("reload_done", 32'(a_done), 32'd1);
      check("reload_crst", 32'(a_core_reset), 32'd0);

      // AUTO_BOOT=0 instance: idle until start, mid-load start ignored
      sel = 1;
      check("b_wait_ready", 32'(b_ready), 32'd0);
      check("b_wait_crst",  32'(b_core_reset), 32'd1);
      check("b_wait_busy",  32'(b_busy), 32'd0);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check("b_start_ready", 32'(b_ready), 32'd1);
      check("b_start_busy",  32'(b_busy), 32'd1);
      for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
      b_valid = 1'b0;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check("b_midstart_busy", 32'(b_busy), 32'd1);
      for (int i = 4; i < 8; i++) send_byte(stream[i], 0);
      send_byte(8'h7B, 0);
      b_valid = 1'b0;
      repeat (4) @(negedge clk);
      check_writes("b_load");
      check("b_done", 32'(b_done), 32'd1);
      check("b_crst", 32'(b_core_reset), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
